fir_core: RTL and testbench
===========================

Name: fir_core

Overview:
- 64-tap FIR compute core with on-chip sample memory (IMEM) and coefficient memory (CMEM).
- A host loads signed Q5.11 samples and coefficients, selects an output index, then pulses multiply and runs accumulate.
- Produces one Q10.22 output sample y[n] = sum over k of c[k]·x[n−k].
- Sits under a host/controller that sequences load, multiply and accumulate phases.

Parameters:
- DATA_W, 16, sample/coefficient width (signed Q5.11)
- ADDR_W, 14, IMEM address width; IMEM depth 2^ADDR_W words
- TAPS, 64, number of taps and CMEM depth (power of 2)
- ACC_W, 32, product and output width (signed Q10.22)

Ports:
- clk  in  1  sole clock, rising edge
- resetn  in  1  reset, synchronous, active-low
- din  in  16  write data for IMEM/CMEM, signed Q5.11
- addr  in  14  IMEM address {block[4:0], offset[8:0]}; CMEM uses addr[5:0]
- dload  in  2  IMEM op: 00 write, 01 select base, 10/11 idle
- cload  in  1  CMEM write enable
- mul_en  in  1  parallel multiply strobe
- acc_en  in  1  adder-tree advance enable
- dout  out  32  filter output, signed Q10.22

Behaviour:
- Reset (resetn=0 at a rising edge): base, all 64 product registers, all tree registers and dout clear to 0. IMEM and CMEM contents are not cleared.
- cload=1: CMEM[addr[5:0]] <= din. cload has priority: with cload=1, no IMEM write occurs regardless of dload.
- dload=00 and cload=0: IMEM[addr] <= din.
- dload=01: base <= addr. dload=10/11: no IMEM action.
- Writes to IMEM/CMEM take effect at the edge; reads return the value after that edge.
- mul_en=1 at an edge, for k=0..63: prod[k] <= signed(IMEM[base−k]) × signed(CMEM[k]).
  - Full 32-bit signed product (Q5.11 × Q5.11 = Q10.22).
  - If base−k < 0, the sample is 0; no wrap-around to the memory top.
- mul_en uses the base registered on an earlier edge. If dload=01 and mul_en coincide, mul_en uses the old base.
- Adder tree: 6 pipelined pairwise stages (64→32→16→8→4→2→1). All stages advance only on edges with acc_en=1.
- dout is the final stage register. It holds the complete sum after the 6th acc_en edge following mul_en, so 1 mul edge + 6 acc edges.
- With acc_en held high and no new mul_en, dout stays constant.
- Arithmetic: sums are two's complement modulo 2^32 (wrap, no saturation).
- mul_en and acc_en both high: products update and the tree advances with the old products. The new sum appears 6 acc edges later.
- Reset mid-operation discards all in-flight products and partial sums. dout=0 on the edge after reset.
- Memory writes during multiply/accumulate are permitted. Results use memory contents at the mul_en edge.

Decomposition:
- Package fir_pkg holds:
  - DATA_W, ADDR_W, TAPS, ACC_W, FRAC_IN=11, FRAC_OUT=22
  - dload encodings DLOAD_WR=2'b00, DLOAD_SEL=2'b01, DLOAD_IDLE=2'b11
- One sub-module, fir_adder_tree: 64 signed ACC_W inputs, enable, 6 registered stages, synchronous active-low reset.
- Memories, base register and multipliers stay in fir_core.

Test Plan:
- All 64 coefs 0x0800 (1.0), IMEM[0..127] = 0x0800, base=65, mul_en pulse, acc_en high 8 cycles -> dout=0x1000_0000 (64.0).
- Single nonzero pair c[3]=0x0800, IMEM[62]=0x0400 (0.5), rest 0, base=65 -> dout=0x0020_0000 (0.5).
- Sign: c[0]=0xF800 (−1.0), IMEM[65]=0x0800, others 0, base=65 -> dout=0xFFC0_0000 (−1.0).
- Boundary: all coefs 1.0, all samples 1.0, base=5 -> only 6 terms -> dout=0x0180_0000 (6.0). Also check dout is unchanged (0) before the 6th acc_en edge.
- acc_en gating: mul_en, then acc_en high 3 cycles, low 5 cycles, high 3 cycles -> dout becomes final exactly on the 6th enabled edge and holds.
- resetn low for one edge mid-accumulate -> dout=0 next cycle. Restarting mul_en+6 acc edges reproduces the correct value; IMEM/CMEM are preserved across the reset.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and types for the 64-tap FIR core.
// Samples and coefficients are Q5.11; products and sums are Q10.22.
package fir_pkg;

    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 14;
    localparam int TAPS        = 64;
    localparam int ACC_W       = 32;
    localparam int FRAC_IN     = 11;
    localparam int FRAC_OUT    = 22;
    localparam int CADDR_W     = $clog2(TAPS);
    localparam int TREE_STAGES = $clog2(TAPS);
    localparam int TREE_NODES  = TAPS - 1;

    localparam logic [1:0] DLOAD_WR   = 2'b00;
    localparam logic [1:0] DLOAD_SEL  = 2'b01;
    localparam logic [1:0] DLOAD_IDLE = 2'b11;

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    // Widening both operands first keeps the full signed 32-bit product.
    function automatic acc_t mul_q(input data_t a, input data_t b);
        return acc_t'(a) * acc_t'(b);
    endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// Pipelined pairwise adder tree: TAPS leaves reduced to one sum over
// log2(TAPS) registered stages, all advancing together on en.
module fir_adder_tree
    import fir_pkg::*;
(
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    en,
    input  logic signed [ACC_W-1:0] leaf [TAPS],
    output logic signed [ACC_W-1:0] root
);

    // Heap layout: node i sums children 2i+1 and 2i+2; the last TAPS
    // entries of node_all are the leaves themselves, so every internal
    // level is exactly one register stage.
    acc_t node_reg [TREE_NODES];
    acc_t node_all [2*TAPS-1];

    genvar gi;
    generate
        for (gi = 0; gi < TREE_NODES; gi++) begin : g_node
            assign node_all[gi] = node_reg[gi];

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    node_reg[gi] <= '0;
                end else if (en) begin
                    node_reg[gi] <= node_all[2*gi+1] + node_all[2*gi+2];
                end
            end
        end

        for (gi = 0; gi < TAPS; gi++) begin : g_leaf
            assign node_all[TREE_NODES+gi] = leaf[gi];
        end
    endgenerate

    assign root = node_reg[0];

endmodule

// File: rtl/fir_core.sv
// 64-tap FIR compute core: sample/coefficient memories, a base pointer,
// one multiplier per tap and a pipelined adder tree producing dout.
module fir_core
    import fir_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic [15:0]       din,
    input  logic [13:0]       addr,
    input  logic [1:0]        dload,
    input  logic              cload,
    input  logic              mul_en,
    input  logic              acc_en,
    output logic [31:0]       dout
);

    logic [DATA_W-1:0] imem [2**ADDR_W];
    logic [DATA_W-1:0] cmem [TAPS];
    logic [ADDR_W-1:0] base_reg;
    acc_t              prod_reg [TAPS];
    acc_t              tree_root;

    // Memories are never reset; a coefficient write blocks any sample write.
    always_ff @(posedge clk) begin
        if (cload) begin
            cmem[addr[CADDR_W-1:0]] <= din;
        end else if (dload == DLOAD_WR) begin
            imem[addr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            base_reg <= '0;
        end else if (dload == DLOAD_SEL) begin
            base_reg <= addr;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < TAPS; gi++) begin : g_tap
            logic [ADDR_W-1:0] idx;
            data_t             sample;
            data_t             coef;

            // Taps reaching below address 0 contribute a zero sample.
            assign idx    = base_reg - ADDR_W'(gi);
            assign sample = (base_reg >= ADDR_W'(gi)) ? imem[idx] : '0;
            assign coef   = cmem[gi];

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    prod_reg[gi] <= '0;
                end else if (mul_en) begin
                    prod_reg[gi] <= mul_q(sample, coef);
                end
            end
        end
    endgenerate

    fir_adder_tree u_tree (
        .clk    (clk),
        .resetn (resetn),
        .en     (acc_en),
        .leaf   (prod_reg),
        .root   (tree_root)
    );

    assign dout = tree_root;

endmodule

// File: tb/tb_fir_core.sv
// Self-checking bench for fir_core: directed test-plan scenarios plus
// randomized traffic compared every cycle against a behavioural model.
module tb_fir_core;

    logic        clk;
    logic        resetn;
    logic [15:0] din;
    logic [13:0] addr;
    logic [1:0]  dload;
    logic        cload;
    logic        mul_en;
    logic        acc_en;
    logic [31:0] dout;

    fir_core dut (
        .clk    (clk),
        .resetn (resetn),
        .din    (din),
        .addr   (addr),
        .dload  (dload),
        .cload  (cload),
        .mul_en (mul_en),
        .acc_en (acc_en),
        .dout   (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: memories, base, the dot product latched by the last
    // multiply, and a delay line of six accumulate edges to the output.
    logic [15:0] imem_m [16384];
    logic [15:0] cmem_m [64];
    logic [13:0] base_m;
    logic [31:0] prod_sum_m;
    logic [31:0] dout_exp;
    logic [31:0] dq [$];

    int n_pass  = 0;
    int n_total = 0;
    bit chk_on  = 1'b0;

    function automatic logic [31:0] dot_product(input logic [13:0] b);
        int s = 0;
        for (int k = 0; k < 64; k++) begin
            if (int'(b) >= k)
                s += int'($signed(imem_m[int'(b) - k])) * int'($signed(cmem_m[k]));
        end
        return s;
    endfunction

    task automatic model_step();
        if (!resetn) begin
            base_m     = '0;
            prod_sum_m = '0;
            dout_exp   = '0;
            dq         = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        end else begin
            if (acc_en) begin
                dq.push_back(prod_sum_m);
                dout_exp = dq.pop_front();
            end
            if (mul_en) prod_sum_m = dot_product(base_m);
            if (dload == 2'b01) base_m = addr;
        end
        if (cload) cmem_m[addr[5:0]] = din;
        else if (dload == 2'b00) imem_m[addr] = din;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(input logic rn, input logic [15:0] d, input logic [13:0] a,
                         input logic [1:0] dl, input logic cl, input logic m, input logic ac);
        resetn = rn; din = d; addr = a; dload = dl; cload = cl; mul_en = m; acc_en = ac;
        cyc();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 16'h0, 14'h0, 2'b11, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic do_reset();
        drive(1'b0, 16'h0, 14'h0, 2'b11, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic wr_imem(input int a, input logic [15:0] d);
        drive(1'b1, d, 14'(a), 2'b00, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic wr_cmem(input int a, input logic [15:0] d);
        drive(1'b1, d, 14'(a), 2'b11, 1'b1, 1'b0, 1'b0);
    endtask
    task automatic sel_base(input int a);
        drive(1'b1, 16'h0, 14'(a), 2'b01, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic mul();
        drive(1'b1, 16'h0, 14'h0, 2'b11, 1'b0, 1'b1, 1'b0);
    endtask
    task automatic acc(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 16'h0, 14'h0, 2'b11, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic pin(input string name, input logic [31:0] lit);
        check({name, "_dout"}, dout, lit);
        check({name, "_model"}, dout_exp, lit);
        $display("%-14s dout=%h expected=%h", name, dout, lit);
    endtask

    // Continuous comparison against the model on every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) check("dout_cycle", dout, dout_exp);
        end
    end

    initial begin
        resetn = 1'b0; din = '0; addr = '0; dload = 2'b11;
        cload = 1'b0; mul_en = 1'b0; acc_en = 1'b0;
        @(negedge clk);
        do_reset();
        do_reset();
        chk_on = 1'b1;
        pin("reset", 32'h0);

        // All ones: 64 terms of 1.0
        for (int k = 0; k < 64; k++) wr_cmem(k, 16'h0800);
        for (int a = 0; a < 256; a++) wr_imem(a, (a < 128) ? 16'h0800 : 16'h0000);
        sel_base(65);
        mul();
        acc(8);
        pin("all_ones", 32'h1000_0000);

        // Single nonzero pair c[3] * x[62]
        for (int k = 0; k < 64; k++) wr_cmem(k, 16'h0000);
        for (int a = 0; a < 128; a++) wr_imem(a, 16'h0000);
        wr_cmem(3, 16'h0800);
        wr_imem(62, 16'h0400);
        mul();
        acc(8);
        pin("single_pair", 32'h0020_0000);

        // Sign: -1.0 * 1.0
        wr_cmem(3, 16'h0000);
        wr_imem(62, 16'h0000);
        wr_cmem(0, 16'hF800);
        wr_imem(65, 16'h0800);
        mul();
        acc(8);
        pin("negative", 32'hFFC0_0000);

        // Boundary: base=5 leaves only six in-range taps
        do_reset();
        for (int k = 0; k < 64; k++) wr_cmem(k, 16'h0800);
        for (int a = 0; a < 128; a++) wr_imem(a, 16'h0800);
        sel_base(5);
        mul();
        acc(5);
        pin("bound_early", 32'h0);
        acc(1);
        pin("boundary", 32'h0180_0000);

        // acc_en gating: result lands on the sixth enabled edge and holds
        sel_base(65);
        mul();
        acc(3);
        idle(5);
        pin("gate_idle", 32'h0180_0000);
        acc(2);
        pin("gate_5th", 32'h0180_0000);
        acc(1);
        pin("gate_6th", 32'h1000_0000);
        acc(3);
        pin("gate_hold", 32'h1000_0000);

        // Reset mid-accumulate, then rerun with preserved memories
        wr_cmem(0, 16'hF800);
        mul();
        acc(3);
        do_reset();
        pin("mid_reset", 32'h0);
        sel_base(65);
        mul();
        acc(6);
        pin("after_reset", 32'h0F80_0000);

        // Randomized traffic, checked each cycle by the compare process
        for (int t = 0; t < 800; t++) begin
            int r;
            r = int'($urandom_range(0, 99));
            resetn = 1'b1; din = 16'($urandom); addr = 14'($urandom_range(0, 255));
            dload = 2'b11; cload = 1'b0;
            mul_en = ($urandom_range(0, 7) == 0);
            acc_en = ($urandom_range(0, 3) != 0);
            if (r < 3) begin
                dload = 2'b00; addr = 14'($urandom);
            end else if (r < 30) begin
                dload = 2'b00;
            end else if (r < 45) begin
                cload = 1'b1; dload = 2'($urandom);
            end else if (r < 55) begin
                dload = 2'b01;
            end else if (r == 99) begin
                resetn = 1'b0;
            end
            cyc();
            $display("txn %0d rn=%0b dl=%0b cl=%0b m=%0b a=%0b addr=%0d dout=%h exp=%h",
                     t, resetn, dload, cload, mul_en, acc_en, addr, dout, dout_exp);
        end

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
